// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit engine: 8N1 or 8-bit plus parity frame onto tx_o
module uart_tx_serializer #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       send_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic HAS_PAR = (PARITY_EN != 0);
    localparam logic ODD     = (PARITY_ODD != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          par_bit;

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                if (send_i) begin
                    shift_reg <= data_i;
                    par_bit   <= (^data_i) ^ ODD;
                    tx_o      <= 1'b0;
                    busy_o    <= 1'b1;
                    cnt       <= '0;
                    bit_idx   <= '0;
                    state     <= START;
                end
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                // Bit boundary: tx_o is only ever updated here, at accept, or at reset
                cnt <= '0;
                case (state)
                    START: begin
                        state <= DATA;
                        tx_o  <= shift_reg[0];
                    end
                    DATA: begin
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (HAS_PAR) begin
                                state <= PARITY;
                                tx_o  <= par_bit;
                            end else begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            tx_o <= shift_reg[1];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx_o  <= 1'b1;
                    end
                    STOP: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                    default: begin
                        state  <= IDLE;
                        tx_o   <= 1'b1;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed bench for uart_tx_serializer (no parity, even, odd)
module tb_uart_tx_serializer;

    localparam int CPB = 10;

    logic       clk_i = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       send_i;
    logic [2:0] tx_w, busy_w, done_w;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    uart_tx_serializer #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .PARITY_EN(0), .PARITY_ODD(0)) u_none (
        .clk_i(clk_i), .rst(rst), .data_i(data_i), .send_i(send_i),
        .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));
    uart_tx_serializer #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk_i(clk_i), .rst(rst), .data_i(data_i), .send_i(send_i),
        .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));
    uart_tx_serializer #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk_i(clk_i), .rst(rst), .data_i(data_i), .send_i(send_i),
        .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic exp_bit(input int c, input logic [7:0] b, input int nb, input logic pb);
        int i;
        i = c / CPB;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && nb == 11) return pb;
        return 1'b1;
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            check("rst_tx", tx_w, 3'b111);
            check("rst_busy", busy_w, 3'b000);
            check("rst_done", done_w, 3'b000);
        end
        rst = 1'b1;
        send_i = 1'b0;
    endtask

    task automatic accept(input logic [7:0] b);
        data_i = b;
        send_i = 1'b1;
        step();
        send_i = 1'b0;
    endtask

    // kind: 0 plain, 1 send/data disturbance while busy, 2 reset at cycle 47
    task automatic run_frame(input int sel, input logic [7:0] b, input int nb, input logic pb, input int kind);
        for (int c = 0; c < nb * CPB; c++) begin
            if (kind == 2 && c == 47) begin
                rst = 1'b0;
                step();
                check("abort_tx", tx_w[sel], 1'b1);
                check("abort_busy", busy_w[sel], 1'b0);
                check("abort_done", done_w[sel], 1'b0);
                rst = 1'b1;
                for (int j = 0; j < 80; j++) begin
                    step();
                    check("post_abort_done", done_w[sel], 1'b0);
                    check("post_abort_tx", tx_w[sel], 1'b1);
                end
                return;
            end
            check($sformatf("tx_c%0d", c), tx_w[sel], exp_bit(c, b, nb, pb));
            check("busy", busy_w[sel], 1'b1);
            check("done_early", done_w[sel], 1'b0);
            if (kind == 1) begin
                if (c == 35) begin send_i = 1'b1; data_i = 8'h3C; end
                if (c == 36) send_i = 1'b0;
                if (c == 50) data_i = 8'hFF;
            end
            step();
        end
        check("done_pulse", done_w[sel], 1'b1);
        check("done_busy", busy_w[sel], 1'b0);
        check("done_tx", tx_w[sel], 1'b1);
    endtask

    task automatic idle_check(input int sel, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            check("idle_tx", tx_w[sel], 1'b1);
            check("idle_busy", busy_w[sel], 1'b0);
            check("idle_done", done_w[sel], 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        data_i = 8'h00;
        send_i = 1'b1;
        do_reset(3);
        idle_check(0, 5);

        // Basic 8N1 frame
        accept(8'hA5);
        run_frame(0, 8'hA5, 10, 1'b0, 0);
        idle_check(0, 5);

        // Parity: 0xA5 has four ones -> even 0, odd 1
        do_reset(1);
        accept(8'hA5);
        run_frame(1, 8'hA5, 11, 1'b0, 0);
        do_reset(1);
        accept(8'hA5);
        run_frame(2, 8'hA5, 11, 1'b1, 0);
        do_reset(1);
        accept(8'h01);
        run_frame(1, 8'h01, 11, 1'b1, 0);

        // send_i and data_i activity while busy
        do_reset(1);
        accept(8'hA5);
        run_frame(0, 8'hA5, 10, 1'b0, 1);
        idle_check(0, 15);

        // Back-to-back: request in done cycle
        accept(8'hA5);
        run_frame(0, 8'hA5, 10, 1'b0, 0);
        accept(8'h0F);
        run_frame(0, 8'h0F, 10, 1'b0, 0);
        idle_check(0, 3);

        // Mid-frame reset, then a clean frame
        accept(8'hA5);
        run_frame(0, 8'hA5, 10, 1'b0, 2);
        accept(8'h81);
        run_frame(0, 8'h81, 10, 1'b0, 0);
        idle_check(0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit engine for the peripheral bus.
- Directly downstream of the UART data register: consumes its 8-bit held byte plus a one-cycle send strobe from the UART control logic.
- Drives the serial TX line with an 8N1 frame, or 8-bit data plus a parity bit when parity is enabled.
- Exposes busy/done status for the control register.

Parameters:
- CLK_FREQ, 10_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 1041 at defaults): clock cycles per serial bit. Must be ≥ 2.
- PARITY_EN, 0: 1 inserts a parity bit between data bit 7 and the stop bit.
- PARITY_ODD, 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd parity.

Ports:
- clk_i input 1: system clock, rising edge.
- rst input 1: reset, synchronous, active-low; clock clk_i.
- data_i input 8: byte to transmit (from UART data register).
- send_i input 1: start request, sampled each rising edge.
- tx_o output 1: serial line, idle high.
- busy_o output 1: high while a frame is in progress.
- done_o output 1: one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=0 at a rising edge):
  - FSM goes to IDLE.
  - Baud counter, bit index and shift register clear to 0.
  - tx_o=1, busy_o=0, done_o=0 from that edge.
  - Reset has priority over everything else and aborts a frame mid-transmission; the line returns high at that edge, with no partial stop bit.
- FSM states and transitions:
  - IDLE → START: on an edge with send_i=1.
  - START → DATA
  - DATA → PARITY, if PARITY_EN=1
  - DATA → STOP, if PARITY_EN=0
  - PARITY → STOP
  - STOP → IDLE
- Accept (IDLE, send_i=1 at edge k):
  - data_i is latched into the shift register at edge k.
  - Parity is computed from the latched byte: XOR of its bits, XORed with PARITY_ODD.
  - From edge k: tx_o=0, busy_o=1.
  - data_i changes after edge k have no effect on the frame.
- Bit timing:
  - The baud counter runs 0..CLKS_PER_BIT-1 within each state.
  - Wrap at CLKS_PER_BIT-1 advances the bit or state.
  - Each bit (start, data, parity, stop) holds tx_o for exactly CLKS_PER_BIT cycles.
- DATA:
  - Data is sent LSB first; tx_o = shift_reg[0].
  - The register shifts right at each bit boundary.
  - A 3-bit index counts 0..7; on index 7 with a counter wrap, the FSM leaves DATA.
- PARITY: tx_o = computed parity bit for CLKS_PER_BIT cycles.
- STOP: tx_o=1 for CLKS_PER_BIT cycles.
- Completion, at the edge ending the stop bit:
  - FSM returns to IDLE.
  - busy_o=0 and done_o=1 for exactly one cycle.
  - Total frame: edge k to done edge = N·CLKS_PER_BIT cycles, where N=10 (no parity) or 11 (parity).
- send_i handling:
  - send_i while busy_o=1 is ignored. It is not queued and has no effect on the line.
  - send_i asserted in the done_o cycle is accepted at the next edge (back-to-back frames). The line then stays high for exactly one extra clock between frames.
- Outputs are registered: tx_o, busy_o and done_o come from flops with no combinational path from inputs.
- Glitch-free constraint: tx_o changes only at bit boundaries, at accept, or at reset.

Test Plan:
Bench uses CLK_FREQ=10_000_000, BAUD=1_000_000, giving CLKS_PER_BIT=10.
- Reset: hold rst=0 three cycles with send_i=1 → tx_o=1, busy_o=0, done_o=0 throughout. After release, FSM stays IDLE until a new send_i edge.
- Basic frame: data_i=0xA5, send_i pulse, PARITY_EN=0.
  - tx_o sequence, each bit held 10 cycles: 0 | 1,0,1,0,0,1,0,1 | 1.
  - done_o pulses exactly 100 cycles after the accept edge; busy_o is high for those 100 cycles.
- Parity: data_i=0xA5 (four ones).
  - PARITY_EN=1, PARITY_ODD=0 → bit 10 = 0.
  - PARITY_ODD=1 → bit 10 = 1.
  - done_o at 110 cycles in both cases.
- Ignore and hold while busy:
  - Pulse send_i with data_i=0x3C at cycle 35 of a 0xA5 frame → frame unchanged, no second frame.
  - Change data_i mid-frame → no effect on tx_o.
- Back-to-back: assert send_i in the done_o cycle with data_i=0x0F → new start bit begins one clock after the stop bit ends; second frame decodes 0x0F.
- Mid-frame reset: rst=0 at cycle 47 of a frame → tx_o=1, busy_o=0 at that edge, and no done_o pulse. A subsequent send_i with 0x81 transmits correctly.
